uvma_riscv_tracer_seq_chkr: RTL and testbench

// - Synthesizable multi-lane retirement-stream checker. Sits on the RVFI-style retire ports of the DUT, beside the tracer agent.
// - Checks order continuity, PC continuity, lane packing, stall timeout and retire-after-halt.
// - Raises sticky error flags, a saturating error count and a first-error capture. Usable in simulation and emulation.

---
 rtl/uvma_riscv_tracer_seq_chkr_pkg.sv | 29 ++
 rtl/uvma_riscv_tracer_seq_chkr_lane.sv | 32 +++
 rtl/uvma_riscv_tracer_seq_chkr.sv | 257 +++++++++++++++++++++++++
 tb/tb_uvma_riscv_tracer_seq_chkr.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uvma_riscv_tracer_seq_chkr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uvma_riscv_tracer_seq_chkr_pkg                                |
// | Purpose  : Shared types and constants for the retirement-stream checker. |
// |            err_idx_e gives the bit position of each error flag,          |
// |            state_e the checker FSM encoding seen on the state port.      |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package uvma_riscv_tracer_seq_chkr_pkg;

   localparam int ERR_W = 5;

   typedef enum logic [2:0] {
      ERR_ORDER     = 3'd0,
      ERR_PC        = 3'd1,
      ERR_LANE      = 3'd2,
      ERR_STALL     = 3'd3,
      ERR_POST_HALT = 3'd4
   } err_idx_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/uvma_riscv_tracer_seq_chkr_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uvma_riscv_tracer_seq_chkr_lane                               |
// | Purpose  : Combinational order / PC compare for one retire lane.         |
// | Ports    : valid_i, intr_i, skip_pc_i   lane qualifiers                  |
// |            order_i, exp_order_i         observed / expected order        |
// |            pc_rdata_i, exp_pc_i         observed / expected PC           |
// |            order_err_o, pc_err_o        lane error bits                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uvma_riscv_tracer_seq_chkr_lane #(
   parameter int XLEN    = 32,
   parameter int ORDER_W = 64
) (
   input  logic               valid_i,
   input  logic               intr_i,
   input  logic               skip_pc_i,
   input  logic [ORDER_W-1:0] order_i,
   input  logic [ORDER_W-1:0] exp_order_i,
   input  logic [XLEN-1:0]    pc_rdata_i,
   input  logic [XLEN-1:0]    exp_pc_i,
   output logic               order_err_o,
   output logic               pc_err_o
);

   assign order_err_o = valid_i && (order_i != exp_order_i);
   // A trap entry legitimately breaks the PC chain, as does the very first
   // retirement after reset (no predecessor known yet).
   assign pc_err_o    = valid_i && !intr_i && !skip_pc_i && (pc_rdata_i != exp_pc_i);

endmodule
`default_nettype wire

// File: rtl/uvma_riscv_tracer_seq_chkr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uvma_riscv_tracer_seq_chkr                                    |
// | Purpose  : Multi-lane RVFI retirement-stream checker: order continuity,  |
// |            PC continuity, lane packing, stall watchdog, retire-after-    |
// |            halt. Sticky flags, saturating count, first-error capture.    |
// | Ports    : clk, reset (async, active-high), clear (sync)                 |
// |            rvfi_valid/order/pc_rdata/pc_wdata/intr/halt  retire lanes    |
// |            err, err_cnt, first_err_kind, first_err_order                 |
// |            retire_cnt, state                                             |
// | Config   : UVMA_RISCV_TRACER_SEQ_CHKR_SVA_EN adds per-error assertions   |
// |            and an X-check on rvfi_valid; outputs are unaffected.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uvma_riscv_tracer_seq_chkr
   import uvma_riscv_tracer_seq_chkr_pkg::*;
#(
   parameter int NRET      = 1,
   parameter int XLEN      = 32,
   parameter int ORDER_W   = 64,
   parameter int ERR_CNT_W = 8,
   parameter int MAX_STALL = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic [NRET-1:0]           rvfi_valid,
   input  logic [NRET*ORDER_W-1:0]   rvfi_order,
   input  logic [NRET*XLEN-1:0]      rvfi_pc_rdata,
   input  logic [NRET*XLEN-1:0]      rvfi_pc_wdata,
   input  logic [NRET-1:0]           rvfi_intr,
   input  logic [NRET-1:0]           rvfi_halt,
   output logic [ERR_W-1:0]          err,
   output logic [ERR_CNT_W-1:0]      err_cnt,
   output logic [2:0]                first_err_kind,
   output logic [ORDER_W-1:0]        first_err_order,
   output logic [ORDER_W-1:0]        retire_cnt,
   output logic [1:0]                state
);

   localparam int K_W = $clog2(NRET + 1);

   state_e                     state_q, state_d;
   logic [ORDER_W-1:0]         exp_order_q, exp_order_d;
   logic [ORDER_W-1:0]         retire_cnt_q, retire_cnt_d;
   logic [XLEN-1:0]            last_pc_q, last_pc_d;
   logic [ERR_W-1:0]           err_q, err_d;
   logic [ERR_CNT_W-1:0]       err_cnt_q, err_cnt_d;
   logic [2:0]                 first_kind_q, first_kind_d;
   logic [ORDER_W-1:0]         first_order_q, first_order_d;

   logic [NRET-1:0][ORDER_W-1:0] lane_exp_order;
   logic [NRET-1:0][XLEN-1:0]    lane_exp_pc;
   logic [NRET-1:0]              lane_skip_pc, lane_gap, lane_post_halt;
   logic [NRET-1:0]              lane_order_err, lane_pc_err;
   logic [K_W-1:0]               k;
   logic [ERR_W-1:0]             new_err;
   logic                         stall_hit;
   logic [2:0]                   cap_kind;
   logic [ORDER_W-1:0]           cap_order;
   logic [NRET-1:0]              kind_mask;

   // Walk the lanes in ascending order; each valid lane consumes the next
   // expected order and hands its pc_wdata to the following valid lane.
   always_comb begin : walk_lanes
      logic [ORDER_W-1:0] run_order;
      logic [XLEN-1:0]    run_pc;
      logic               first_pending, gap_seen, halt_seen;
      run_order      = exp_order_q;
      run_pc         = last_pc_q;
      first_pending  = (state_q == ST_IDLE);
      gap_seen       = 1'b0;
      halt_seen      = (state_q == ST_HALTED);
      k              = '0;
      lane_exp_order = '0;
      lane_exp_pc    = '0;
      lane_skip_pc   = '0;
      lane_gap       = '0;
      lane_post_halt = '0;
      for (int i = 0; i < NRET; i++) begin
         lane_exp_order[i] = run_order;
         lane_exp_pc[i]    = run_pc;
         lane_skip_pc[i]   = first_pending;
         lane_gap[i]       = rvfi_valid[i] & gap_seen;
         lane_post_halt[i] = rvfi_valid[i] & halt_seen;
         if (rvfi_valid[i]) begin
            run_order     = run_order + ORDER_W'(1);
            run_pc        = rvfi_pc_wdata[i*XLEN +: XLEN];
            first_pending = 1'b0;
            k             = k + K_W'(1);
            if (rvfi_halt[i]) halt_seen = 1'b1;
         end else begin
            gap_seen = 1'b1;
         end
      end
      exp_order_d = run_order;
      last_pc_d   = run_pc;
   end

   for (genvar g = 0; g < NRET; g++) begin : g_lane
      uvma_riscv_tracer_seq_chkr_lane #(
         .XLEN    (XLEN),
         .ORDER_W (ORDER_W)
      ) u_lane (
         .valid_i     (rvfi_valid[g]),
         .intr_i      (rvfi_intr[g]),
         .skip_pc_i   (lane_skip_pc[g]),
         .order_i     (rvfi_order[g*ORDER_W +: ORDER_W]),
         .exp_order_i (lane_exp_order[g]),
         .pc_rdata_i  (rvfi_pc_rdata[g*XLEN +: XLEN]),
         .exp_pc_i    (lane_exp_pc[g]),
         .order_err_o (lane_order_err[g]),
         .pc_err_o    (lane_pc_err[g])
      );
   end

   // Stall watchdog: the counter parks at MAX_STALL so the flag fires once
   // per stall episode.
   if (MAX_STALL > 0) begin : g_stall
      localparam int SC_W = $clog2(MAX_STALL + 1);
      logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;

      always_comb begin
         stall_cnt_d = stall_cnt_q;
         if ((state_q != ST_RUN) || (|rvfi_valid))
            stall_cnt_d = '0;
         else if (stall_cnt_q != SC_W'(MAX_STALL))
            stall_cnt_d = stall_cnt_q + SC_W'(1);
      end

      assign stall_hit = (state_q == ST_RUN) && !(|rvfi_valid)
                         && (stall_cnt_q == SC_W'(MAX_STALL - 1));

      always_ff @(posedge clk or posedge reset) begin
         if (reset) stall_cnt_q <= '0;
         else       stall_cnt_q <= stall_cnt_d;
      end
   end else begin : g_no_stall
      assign stall_hit = 1'b0;
   end

   assign new_err[ERR_ORDER]     = |lane_order_err;
   assign new_err[ERR_PC]        = |lane_pc_err;
   assign new_err[ERR_LANE]      = |lane_gap;
   assign new_err[ERR_STALL]     = stall_hit;
   assign new_err[ERR_POST_HALT] = |lane_post_halt;

   // Lowest new error kind, then the lowest lane that exhibits it.
   always_comb begin : first_capture
      cap_kind = ERR_ORDER;
      for (int b = ERR_W - 1; b >= 0; b--)
         if (new_err[b]) cap_kind = 3'(b);
      case (cap_kind)
         ERR_ORDER:     kind_mask = lane_order_err;
         ERR_PC:        kind_mask = lane_pc_err;
         ERR_LANE:      kind_mask = lane_gap;
         ERR_POST_HALT: kind_mask = lane_post_halt;
         default:       kind_mask = '0;
      endcase
      cap_order = '0;
      for (int i = NRET - 1; i >= 0; i--)
         if (kind_mask[i]) cap_order = rvfi_order[i*ORDER_W +: ORDER_W];
   end

   // clear acts before same-cycle new errors, so they become the first error.
   always_comb begin : err_next
      err_d         = err_q;
      err_cnt_d     = err_cnt_q;
      first_kind_d  = first_kind_q;
      first_order_d = first_order_q;
      if (clear) begin
         err_d         = '0;
         err_cnt_d     = '0;
         first_kind_d  = '0;
         first_order_d = '0;
      end
      if (|new_err) begin
         if (err_d == '0) begin
            first_kind_d  = cap_kind;
            first_order_d = cap_order;
         end
         err_d = err_d | new_err;
         if (err_cnt_d != '1) err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
      end
   end

   always_comb begin : fsm_next
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (|rvfi_valid) state_d = ST_RUN;
         ST_RUN:    if (|(rvfi_valid & rvfi_halt)) state_d = ST_HALTED;
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign retire_cnt_d = retire_cnt_q + ORDER_W'(k);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         exp_order_q   <= '0;
         retire_cnt_q  <= '0;
         last_pc_q     <= '0;
         err_q         <= '0;
         err_cnt_q     <= '0;
         first_kind_q  <= '0;
         first_order_q <= '0;
      end else begin
         state_q       <= state_d;
         exp_order_q   <= exp_order_d;
         retire_cnt_q  <= retire_cnt_d;
         last_pc_q     <= last_pc_d;
         err_q         <= err_d;
         err_cnt_q     <= err_cnt_d;
         first_kind_q  <= first_kind_d;
         first_order_q <= first_order_d;
      end
   end

   assign err             = err_q;
   assign err_cnt         = err_cnt_q;
   assign first_err_kind  = first_kind_q;
   assign first_err_order = first_order_q;
   assign retire_cnt      = retire_cnt_q;
   assign state           = state_q;

`ifdef UVMA_RISCV_TRACER_SEQ_CHKR_SVA_EN
   logic [ERR_W-1:0][NRET-1:0] lane_err_mask;
   assign lane_err_mask[ERR_ORDER]     = lane_order_err;
   assign lane_err_mask[ERR_PC]        = lane_pc_err;
   assign lane_err_mask[ERR_LANE]      = lane_gap;
   assign lane_err_mask[ERR_STALL]     = '0;
   assign lane_err_mask[ERR_POST_HALT] = lane_post_halt;

   for (genvar b = 0; b < ERR_W; b++) begin : g_sva_err
      int                 sva_lane;
      logic [ORDER_W-1:0] sva_order;
      always_comb begin
         sva_lane  = 0;
         sva_order = '0;
         for (int i = NRET - 1; i >= 0; i--)
            if (lane_err_mask[b][i]) begin
               sva_lane  = i;
               sva_order = rvfi_order[i*ORDER_W +: ORDER_W];
            end
      end
      a_no_new_err: assert property (@(posedge clk) disable iff (reset) !new_err[b])
         else $error("seq_chkr: error bit %0d at lane %0d order 0x%0h", b, sva_lane, sva_order);
   end

   a_valid_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(rvfi_valid))
      else $error("seq_chkr: rvfi_valid unknown (0b%b), expected order 0x%0h", rvfi_valid, exp_order_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_uvma_riscv_tracer_seq_chkr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uvma_riscv_tracer_seq_chkr                                 |
// | Purpose  : Self-checking bench for the retirement-stream checker,        |
// |            NRET=2, XLEN=32, ORDER_W=64, ERR_CNT_W=3, MAX_STALL=16.       |
// |            Directed scenarios plus random traffic against a list-based   |
// |            reference model of the retirement rules.                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uvma_riscv_tracer_seq_chkr;

   localparam int NRET = 2;
   localparam int XLEN = 32;
   localparam int OW   = 64;
   localparam int ECW  = 3;
   localparam int MS   = 16;

   logic              clk = 1'b0;
   logic              reset, clear;
   logic [NRET-1:0]   valid, intr, halt;
   logic [NRET*OW-1:0]   order;
   logic [NRET*XLEN-1:0] pcr, pcw;
   logic [4:0]        err;
   logic [ECW-1:0]    err_cnt;
   logic [2:0]        first_err_kind;
   logic [OW-1:0]     first_err_order, retire_cnt;
   logic [1:0]        state;

   int checks = 0;
   int errors = 0;

   // reference model state
   longint unsigned m_exp, m_retire, m_forder;
   logic [31:0]     m_last_pc;
   int              m_state, m_idle, m_cnt, m_kind;
   logic [4:0]      m_err;

   uvma_riscv_tracer_seq_chkr #(
      .NRET(NRET), .XLEN(XLEN), .ORDER_W(OW), .ERR_CNT_W(ECW), .MAX_STALL(MS)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .rvfi_valid(valid), .rvfi_order(order), .rvfi_pc_rdata(pcr), .rvfi_pc_wdata(pcw),
      .rvfi_intr(intr), .rvfi_halt(halt),
      .err(err), .err_cnt(err_cnt), .first_err_kind(first_err_kind),
      .first_err_order(first_err_order), .retire_cnt(retire_cnt), .state(state)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_exp = 0; m_retire = 0; m_forder = 0; m_last_pc = 0;
      m_state = 0; m_idle = 0; m_cnt = 0; m_kind = 0; m_err = 0;
   endtask

   // Applies one cycle of the retirement rules to the currently driven inputs.
   task automatic model_step();
      int          idx[$];
      int          lane_of[5];
      logic [4:0]  nb;
      logic [31:0] cur;
      bit          first, stopped;
      nb = 0;
      for (int b = 0; b < 5; b++) lane_of[b] = -1;
      for (int i = 0; i < NRET; i++) if (valid[i]) idx.push_back(i);
      cur = m_last_pc; first = (m_state == 0); stopped = (m_state == 2);
      foreach (idx[m]) begin
         int i;
         longint unsigned o;
         i = idx[m];
         o = order[i*OW +: OW];
         if (i != m) begin nb[2] = 1; if (lane_of[2] < 0) lane_of[2] = i; end
         if (o != m_exp + longint'(m)) begin nb[0] = 1; if (lane_of[0] < 0) lane_of[0] = i; end
         if (!intr[i] && !first && pcr[i*XLEN +: XLEN] != cur) begin nb[1] = 1; if (lane_of[1] < 0) lane_of[1] = i; end
         if (stopped) begin nb[4] = 1; if (lane_of[4] < 0) lane_of[4] = i; end
         if (halt[i]) stopped = 1;
         cur = pcw[i*XLEN +: XLEN]; first = 0;
      end
      if (m_state == 1 && idx.size() == 0) begin
         if (m_idle < MS) begin m_idle++; if (m_idle == MS) nb[3] = 1; end
      end else m_idle = 0;
      if (clear) begin m_err = 0; m_cnt = 0; m_kind = 0; m_forder = 0; end
      if (nb != 0) begin
         if (m_err == 0) begin
            int kk;
            kk = 4;
            for (int b = 4; b >= 0; b--) if (nb[b]) kk = b;
            m_kind = kk;
            m_forder = (lane_of[kk] >= 0) ? order[lane_of[kk]*OW +: OW] : 64'd0;
         end
         m_err = m_err | nb;
         if (m_cnt < (1 << ECW) - 1) m_cnt++;
      end
      if (m_state == 0 && idx.size() > 0) m_state = 1;
      else if (m_state == 1 && (valid & halt) != 0) m_state = 2;
      m_retire += idx.size();
      m_exp    += idx.size();
      if (idx.size() > 0) m_last_pc = cur;
   endtask

   task automatic drive_idle();
      valid = '0; intr = '0; halt = '0; order = '0; pcr = '0; pcw = '0; clear = 1'b0;
   endtask

   task automatic set_lane(input int i, input longint unsigned o, input logic [31:0] r,
                           input logic [31:0] w, input bit it, input bit h);
      valid[i] = 1'b1; order[i*OW +: OW] = o; pcr[i*XLEN +: XLEN] = r;
      pcw[i*XLEN +: XLEN] = w; intr[i] = it; halt[i] = h;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic do_reset();
      drive_idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      reset = 1'b1;
      #3;
      checks++; if (err !== 5'b0) begin errors++; $display("FAIL reset.err act=%b req=%b", err, 5'b0); end
      checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset.err_cnt act=%0d req=0", err_cnt); end
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset.state act=%0d req=0", state); end
      checks++; if (retire_cnt !== '0) begin errors++; $display("FAIL reset.retire_cnt act=%0d req=0", retire_cnt); end
      checks++; if (first_err_order !== '0 || first_err_kind !== 3'd0) begin errors++;
         $display("FAIL reset.first_err act=%0d/%0h req=0/0", first_err_kind, first_err_order); end
      do_reset();
   endtask

   task automatic test_chain();
      do_reset();
      set_lane(0, 0, 32'h100, 32'h104, 0, 0); set_lane(1, 1, 32'h104, 32'h108, 0, 0); tick();
      checks++; if (retire_cnt !== 64'd2) begin errors++; $display("FAIL chain.retire1 act=%0d req=2", retire_cnt); end
      set_lane(0, 2, 32'h108, 32'h10c, 0, 0); set_lane(1, 3, 32'h10c, 32'h110, 0, 0); tick();
      checks++; if (err !== 5'b0) begin errors++; $display("FAIL chain.err act=%b req=00000", err); end
      checks++; if (retire_cnt !== 64'd4) begin errors++; $display("FAIL chain.retire2 act=%0d req=4", retire_cnt); end
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL chain.state act=%0d req=1", state); end
   endtask

   task automatic test_order_err();
      do_reset();
      set_lane(0, 0, 32'h100, 32'h104, 0, 0); set_lane(1, 1, 32'h104, 32'h108, 0, 0); tick();
      set_lane(0, 3, 32'h108, 32'h10c, 0, 0); tick();
      checks++; if (err !== 5'b00001) begin errors++; $display("FAIL order.err act=%b req=00001", err); end
      checks++; if (first_err_kind !== 3'd0 || first_err_order !== 64'd3) begin errors++;
         $display("FAIL order.first act=%0d/%0d req=0/3", first_err_kind, first_err_order); end
      checks++; if (err_cnt !== 3'd1) begin errors++; $display("FAIL order.err_cnt act=%0d req=1", err_cnt); end
   endtask

   task automatic test_pc();
      do_reset();
      set_lane(0, 0, 32'h100, 32'h104, 0, 0); tick();
      set_lane(0, 1, 32'h200, 32'h204, 0, 0); tick();
      checks++; if (err !== 5'b00010 || first_err_kind !== 3'd1 || first_err_order !== 64'd1) begin errors++;
         $display("FAIL pc.err act=%b/%0d/%0d req=00010/1/1", err, first_err_kind, first_err_order); end
      do_reset();
      set_lane(0, 0, 32'h100, 32'h104, 0, 0); tick();
      set_lane(0, 1, 32'h200, 32'h204, 1, 0); tick();
      checks++; if (err !== 5'b0 || err_cnt !== 3'd0) begin errors++;
         $display("FAIL pc_intr.err act=%b/%0d req=00000/0", err, err_cnt); end
   endtask

   task automatic test_lane();
      do_reset();
      set_lane(0, 0, 32'h100, 32'h104, 0, 0); tick();
      set_lane(1, 1, 32'h104, 32'h108, 0, 0); tick();
      checks++; if (err !== 5'b00100 || first_err_kind !== 3'd2 || first_err_order !== 64'd1) begin errors++;
         $display("FAIL lane.err act=%b/%0d/%0d req=00100/2/1", err, first_err_kind, first_err_order); end
   endtask

   task automatic test_stall();
      do_reset();
      set_lane(0, 0, 32'h100, 32'h104, 0, 0); tick();
      repeat (MS - 1) tick();
      checks++; if (err !== 5'b0) begin errors++; $display("FAIL stall.early act=%b req=00000", err); end
      tick();
      checks++; if (err !== 5'b01000 || err_cnt !== 3'd1 || first_err_kind !== 3'd3 || first_err_order !== 64'd0) begin
         errors++; $display("FAIL stall.hit act=%b/%0d/%0d/%0d req=01000/1/3/0", err, err_cnt, first_err_kind, first_err_order); end
      repeat (10) tick();
      checks++; if (err_cnt !== 3'd1) begin errors++; $display("FAIL stall.once act=%0d req=1", err_cnt); end
      set_lane(0, 1, 32'h104, 32'h108, 0, 0); tick();
      repeat (MS) tick();
      checks++; if (err_cnt !== 3'd2 || err !== 5'b01000) begin errors++;
         $display("FAIL stall.again act=%0d/%b req=2/01000", err_cnt, err); end
   endtask

   task automatic test_halt();
      do_reset();
      set_lane(0, 0, 32'h100, 32'h104, 0, 0); tick();
      set_lane(0, 1, 32'h104, 32'h108, 0, 1); set_lane(1, 2, 32'h108, 32'h10c, 0, 0); tick();
      checks++; if (err !== 5'b10000 || state !== 2'd2 || first_err_order !== 64'd2 || first_err_kind !== 3'd4) begin
         errors++; $display("FAIL halt.err act=%b/%0d/%0d req=10000/2/2", err, state, first_err_order); end
      set_lane(0, 3, 32'h10c, 32'h110, 0, 0); tick();
      checks++; if (err_cnt !== 3'd2 || state !== 2'd2) begin errors++;
         $display("FAIL halt.post act=%0d/%0d req=2/2", err_cnt, state); end
   endtask

   task automatic test_clear();
      do_reset();
      set_lane(0, 0, 32'h100, 32'h104, 0, 0); tick();
      set_lane(0, 5, 32'h104, 32'h108, 0, 0); tick();
      checks++; if (err !== 5'b00001) begin errors++; $display("FAIL clear.pre act=%b req=00001", err); end
      set_lane(0, 2, 32'h300, 32'h304, 0, 0); clear = 1'b1; tick();
      checks++; if (err !== 5'b00010 || err_cnt !== 3'd1 || first_err_kind !== 3'd1 || first_err_order !== 64'd2) begin
         errors++; $display("FAIL clear.same act=%b/%0d/%0d/%0d req=00010/1/1/2", err, err_cnt, first_err_kind, first_err_order); end
      clear = 1'b1; tick();
      checks++; if (err !== 5'b0 || err_cnt !== 3'd0 || retire_cnt !== 64'd3) begin errors++;
         $display("FAIL clear.only act=%b/%0d/%0d req=00000/0/3", err, err_cnt, retire_cnt); end
   endtask

   task automatic test_saturate();
      do_reset();
      set_lane(0, 0, 32'h100, 32'h104, 0, 0); tick();
      for (int c = 0; c < 9; c++) begin
         set_lane(0, m_exp + 7, m_last_pc, m_last_pc + 4, 0, 0); tick();
      end
      checks++; if (err_cnt !== 3'd7) begin errors++; $display("FAIL saturate.cnt act=%0d req=7", err_cnt); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_lane(0, 0, 32'h100, 32'h104, 0, 0); set_lane(1, 1, 32'h104, 32'h108, 0, 0); tick();
      do_reset();
      set_lane(0, 0, 32'h500, 32'h504, 0, 0); tick();
      checks++; if (err !== 5'b0 || state !== 2'd1 || retire_cnt !== 64'd1) begin errors++;
         $display("FAIL reset_mid act=%b/%0d/%0d req=00000/1/1", err, state, retire_cnt); end
   endtask

   task automatic test_random();
      int burst;
      burst = 0;
      for (int seg = 0; seg < 3; seg++) begin
         do_reset();
         for (int c = 0; c < 300; c++) begin
            logic [31:0] pc;
            int r, rank;
            drive_idle();
            clear = ($urandom_range(0, 29) == 0);
            if (burst > 0) burst--;
            else if ($urandom_range(0, 99) == 0) burst = MS + 2;
            else begin
               r = $urandom_range(0, 19);
               valid = (r < 6) ? 2'b00 : (r < 12) ? 2'b01 : (r < 19) ? 2'b11 : 2'b10;
               pc = m_last_pc; rank = 0;
               for (int i = 0; i < NRET; i++) if (valid[i]) begin
                  logic [31:0] nxt;
                  nxt = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc + 32'd4;
                  order[i*OW +: OW] = m_exp + longint'(rank) + (($urandom_range(0, 24) == 0) ? 64'd1 : 64'd0);
                  intr[i] = ($urandom_range(0, 9) == 0);
                  pcr[i*XLEN +: XLEN] = intr[i] ? ($urandom & 32'hFFFF_FFFC)
                                       : (($urandom_range(0, 24) == 0) ? (pc ^ 32'h10) : pc);
                  pcw[i*XLEN +: XLEN] = nxt;
                  halt[i] = ($urandom_range(0, 249) == 0);
                  pc = nxt; rank++;
               end
            end
            tick();
            checks++; if (err !== m_err) begin errors++; $display("FAIL rand.err act=%b req=%b", err, m_err); end
            checks++; if (err_cnt !== ECW'(m_cnt)) begin errors++; $display("FAIL rand.err_cnt act=%0d req=%0d", err_cnt, m_cnt); end
            checks++; if (first_err_kind !== 3'(m_kind)) begin errors++; $display("FAIL rand.kind act=%0d req=%0d", first_err_kind, m_kind); end
            checks++; if (first_err_order !== m_forder) begin errors++; $display("FAIL rand.forder act=%0d req=%0d", first_err_order, m_forder); end
            checks++; if (retire_cnt !== m_retire) begin errors++; $display("FAIL rand.retire act=%0d req=%0d", retire_cnt, m_retire); end
            checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rand.state act=%0d req=%0d", state, m_state); end
         end
      end
   endtask

   initial begin
      model_reset();
      drive_idle();
      reset = 1'b0;
      test_reset();
      test_chain();
      test_order_err();
      test_pc();
      test_lane();
      test_stall();
      test_halt();
      test_clear();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
